axi_master_arbiter: RTL and testbench
=====================================

AXI_MASTER_ARBITER -- requirements
Module: axi_master_arbiter

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority to requester 0.
REQ-002 Port clk_i SHALL be an input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 Port rst_i SHALL be an input, 1 bit: reset, synchronous and active-high.
REQ-004 Port slv0_req_i SHALL be an input of type axi_conf::req_t: requester 0 request.
REQ-005 Port slv0_resp_o SHALL be an output of type axi_conf::resp_t: requester 0 response.
REQ-006 Port slv1_req_i SHALL be an input of type axi_conf::req_t: requester 1 request.
REQ-007 Port slv1_resp_o SHALL be an output of type axi_conf::resp_t: requester 1 response.
REQ-008 Port mst_req_o SHALL be an output of type axi_conf::req_t: shared master request, toward the AXI master connector.
REQ-009 Port mst_resp_i SHALL be an input of type axi_conf::resp_t: shared master response.

Function
REQ-010 Write and read paths SHALL be arbitrated independently; each path has its own FSM, grant register and priority bit.
REQ-011 Write FSM states and transitions SHALL be:
- W_IDLE -> W_ADDR on any aw_valid;
- W_ADDR -> W_DATA on mst aw handshake;
- W_DATA -> W_RESP on mst w handshake with w.last=1;
- W_RESP -> W_IDLE on mst b handshake.
REQ-012 Read FSM states and transitions SHALL be:
- R_IDLE -> R_ADDR on any ar_valid;
- R_ADDR -> R_DATA on mst ar handshake;
- R_DATA -> R_IDLE on mst r handshake with r.last=1.
REQ-013 On leaving IDLE, the grant register SHALL latch:
- the sole valid requester, or
- the priority holder when both are valid.
REQ-014 The grant SHALL be held until the path returns to IDLE; no preemption mid-transaction.
REQ-015 With RR_EN=1, the priority bit SHALL point to the non-granted requester on return to IDLE; with RR_EN=0 it SHALL stay 0.
REQ-016 mst aw/w payloads SHALL be muxed from the granted requester.
REQ-017 mst aw_valid SHALL be asserted only in W_ADDR, and w_valid only in W_DATA.
REQ-018 mst b_ready SHALL equal the granted requester's b_ready in W_RESP and be 0 otherwise.
REQ-019 The granted requester SHALL see:
- aw_ready = mst aw_ready in W_ADDR;
- w_ready = mst w_ready in W_DATA;
- b and b_valid from mst in W_RESP.
REQ-020 All of a requester's write ready/valid responses SHALL be 0 whenever it is not granted or the FSM is in another state.
REQ-021 The read path SHALL behave as REQ-016 to REQ-020 with ar/r in place of aw/w/b.
REQ-022 A transaction's ar_valid SHALL reach the master in R_ADDR; r beats SHALL be forwarded to the granted requester in R_DATA.
REQ-023 Arbitration latency SHALL be exactly one cycle: a request valid in cycle N at IDLE yields mst valid in cycle N+1.
REQ-024 Both returns to IDLE (W_RESP to W_IDLE and R_DATA to R_IDLE) SHALL cost one bubble cycle before the next grant.
REQ-025 A W beat presented before its AW is granted SHALL be back-pressured (w_ready=0), never dropped.
REQ-026 A single-beat write (len=0) SHALL pass W_DATA in one handshake.
REQ-027 Response ids/resp/user SHALL pass unchanged; the block SHALL not inspect or remap ids.
REQ-028 Simultaneous write and read activity from the same or different requesters SHALL proceed concurrently.

Reset
REQ-029 While rst_i=1 at a clock edge, both FSMs SHALL go to IDLE, both grant registers to 0 and both priority bits to 0.
REQ-030 During and after reset, all mst valid/ready signals and all slave valid/ready signals SHALL be 0 until a new grant.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction with no completion to either requester.

Structure
REQ-032 The state enumerations w_state_e and r_state_e SHALL reside in a shared package, axi_io_pmp_arb_pkg; requester index width 1 SHALL be a package constant.
REQ-033 The AXI types SHALL remain in axi_conf.
REQ-034 One sub-module, axi_rr_grant (priority bit plus grant latch, used twice), SHALL be instantiated for the write and read paths.

Verification
REQ-035 A bench SHALL cover: both slaves assert aw_valid at cycle 2 after reset, RR_EN=1 -> slave0 granted first, mst aw_valid at cycle 3; after its B, slave1 granted with aw_valid 1 cycle after IDLE.
REQ-036 A bench SHALL cover: slave1 issues a len=3 write while slave0 issues ar len=0 -> 4 w beats routed to slave1, r beat routed to slave0 concurrently; slave0 sees w_ready=0 throughout.
REQ-037 A bench SHALL cover: RR_EN=0, both slaves request reads continuously for 4 transactions -> slave0 wins all 4; slave1 ar_ready stays 0.
REQ-038 A bench SHALL cover: slave0 presents w_valid 3 cycles before aw_valid -> w_ready stays 0 until W_DATA; all beats delivered with wlast on beat len+1.
REQ-039 A bench SHALL cover: rst_i asserted in R_DATA after 2 of 4 beats -> next cycle all valids/readys 0, FSM R_IDLE, priority 0.
REQ-040 A bench SHALL cover: mst b carries id=0x5A, resp=SLVERR to slave1 -> slave1_resp_o.b.id=0x5A, resp=2'b10, slave0 b_valid=0.

Source files
------------

// File: rtl/axi_conf.sv
// AXI channel payloads and the request/response bundles shared by all AXI blocks.
package axi_conf;

    localparam int unsigned ID_W   = 8;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned USER_W = 4;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic [USER_W-1:0] user;
    } ax_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
        logic [USER_W-1:0] user;
    } w_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [1:0]        resp;
        logic [USER_W-1:0] user;
    } b_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
        logic [USER_W-1:0] user;
    } r_t;

    typedef struct packed {
        ax_t  aw;
        logic aw_valid;
        w_t   w;
        logic w_valid;
        logic b_ready;
        ax_t  ar;
        logic ar_valid;
        logic r_ready;
    } req_t;

    typedef struct packed {
        logic aw_ready;
        logic w_ready;
        b_t   b;
        logic b_valid;
        logic ar_ready;
        r_t   r;
        logic r_valid;
    } resp_t;

endpackage

// File: rtl/axi_io_pmp_arb_pkg.sv
// Arbiter FSM state encodings and requester index width.
package axi_io_pmp_arb_pkg;

    localparam int unsigned IDX_W = 1;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } r_state_e;

endpackage

// File: rtl/axi_rr_grant.sv
// Two-requester grant latch with a round-robin priority bit.
module axi_rr_grant
    import axi_io_pmp_arb_pkg::*;
#(
    parameter int unsigned RR_EN = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       i_req,
    input  logic             i_latch,
    input  logic             i_release,
    output logic [IDX_W-1:0] o_grant
);

    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] r_prio;
    logic [IDX_W-1:0] w_pick;

    // Sole requester wins; a tie goes to the priority holder.
    always_comb begin
        w_pick = r_prio;
        if (i_req == 2'b01) begin
            w_pick = IDX_W'(0);
        end else if (i_req == 2'b10) begin
            w_pick = IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_grant <= '0;
            r_prio  <= '0;
        end else begin
            if (i_latch) begin
                r_grant <= w_pick;
            end
            if (i_release) begin
                r_prio <= (RR_EN != 0) ? ~r_grant : IDX_W'(0);
            end
        end
    end

    assign o_grant = r_grant;

endmodule

// File: rtl/axi_master_arbiter.sv
// Two-to-one AXI arbiter with independent, non-preemptive write and read paths.
module axi_master_arbiter
    import axi_io_pmp_arb_pkg::*;
#(
    parameter int unsigned RR_EN = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  axi_conf::req_t  slv0_req_i,
    output axi_conf::resp_t slv0_resp_o,
    input  axi_conf::req_t  slv1_req_i,
    output axi_conf::resp_t slv1_resp_o,
    output axi_conf::req_t  mst_req_o,
    input  axi_conf::resp_t mst_resp_i
);

    w_state_e         r_wr_state, w_wr_state_nxt;
    r_state_e         r_rd_state, w_rd_state_nxt;
    logic [IDX_W-1:0] w_wr_gnt, w_rd_gnt;
    logic             w_wr_latch, w_wr_release, w_rd_latch, w_rd_release;

    axi_conf::ax_t    w_aw_sel, w_ar_sel;
    axi_conf::w_t     w_w_sel;
    logic             w_aw_vld_sel, w_w_vld_sel, w_b_rdy_sel, w_ar_vld_sel, w_r_rdy_sel;
    logic             w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic             w_wr_aw_rdy, w_wr_w_rdy, w_wr_b_vld, w_rd_ar_rdy, w_rd_r_vld;

    // Payload and handshake muxes follow the latched grant of each path.
    always_comb begin
        w_aw_sel     = (w_wr_gnt == IDX_W'(1)) ? slv1_req_i.aw       : slv0_req_i.aw;
        w_aw_vld_sel = (w_wr_gnt == IDX_W'(1)) ? slv1_req_i.aw_valid : slv0_req_i.aw_valid;
        w_w_sel      = (w_wr_gnt == IDX_W'(1)) ? slv1_req_i.w        : slv0_req_i.w;
        w_w_vld_sel  = (w_wr_gnt == IDX_W'(1)) ? slv1_req_i.w_valid  : slv0_req_i.w_valid;
        w_b_rdy_sel  = (w_wr_gnt == IDX_W'(1)) ? slv1_req_i.b_ready  : slv0_req_i.b_ready;
        w_ar_sel     = (w_rd_gnt == IDX_W'(1)) ? slv1_req_i.ar       : slv0_req_i.ar;
        w_ar_vld_sel = (w_rd_gnt == IDX_W'(1)) ? slv1_req_i.ar_valid : slv0_req_i.ar_valid;
        w_r_rdy_sel  = (w_rd_gnt == IDX_W'(1)) ? slv1_req_i.r_ready  : slv0_req_i.r_ready;
    end

    assign w_wr_aw_rdy  = (r_wr_state == W_ADDR) && mst_resp_i.aw_ready;
    assign w_wr_w_rdy   = (r_wr_state == W_DATA) && mst_resp_i.w_ready;
    assign w_wr_b_vld   = (r_wr_state == W_RESP) && mst_resp_i.b_valid;
    assign w_rd_ar_rdy  = (r_rd_state == R_ADDR) && mst_resp_i.ar_ready;
    assign w_rd_r_vld   = (r_rd_state == R_DATA) && mst_resp_i.r_valid;

    assign w_aw_hs      = w_wr_aw_rdy && w_aw_vld_sel;
    assign w_w_hs       = w_wr_w_rdy && w_w_vld_sel;
    assign w_b_hs       = w_wr_b_vld && w_b_rdy_sel;
    assign w_ar_hs      = w_rd_ar_rdy && w_ar_vld_sel;
    assign w_r_hs       = w_rd_r_vld && w_r_rdy_sel;

    assign w_wr_latch   = (r_wr_state == W_IDLE) && (slv0_req_i.aw_valid || slv1_req_i.aw_valid);
    assign w_wr_release = w_b_hs;
    assign w_rd_latch   = (r_rd_state == R_IDLE) && (slv0_req_i.ar_valid || slv1_req_i.ar_valid);
    assign w_rd_release = w_r_hs && mst_resp_i.r.last;

    axi_rr_grant #(.RR_EN(RR_EN)) u_wr_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_req     ({slv1_req_i.aw_valid, slv0_req_i.aw_valid}),
        .i_latch   (w_wr_latch),
        .i_release (w_wr_release),
        .o_grant   (w_wr_gnt)
    );

    axi_rr_grant #(.RR_EN(RR_EN)) u_rd_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_req     ({slv1_req_i.ar_valid, slv0_req_i.ar_valid}),
        .i_latch   (w_rd_latch),
        .i_release (w_rd_release),
        .o_grant   (w_rd_gnt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_state <= W_IDLE;
            r_rd_state <= R_IDLE;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_rd_state <= w_rd_state_nxt;
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            W_IDLE:  if (w_wr_latch) w_wr_state_nxt = W_ADDR;
            W_ADDR:  if (w_aw_hs) w_wr_state_nxt = W_DATA;
            W_DATA:  if (w_w_hs && w_w_sel.last) w_wr_state_nxt = W_RESP;
            W_RESP:  if (w_b_hs) w_wr_state_nxt = W_IDLE;
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            R_IDLE:  if (w_rd_latch) w_rd_state_nxt = R_ADDR;
            R_ADDR:  if (w_ar_hs) w_rd_state_nxt = R_DATA;
            R_DATA:  if (w_rd_release) w_rd_state_nxt = R_IDLE;
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        mst_req_o          = '0;
        mst_req_o.aw       = w_aw_sel;
        mst_req_o.aw_valid = (r_wr_state == W_ADDR) && w_aw_vld_sel;
        mst_req_o.w        = w_w_sel;
        mst_req_o.w_valid  = (r_wr_state == W_DATA) && w_w_vld_sel;
        mst_req_o.b_ready  = (r_wr_state == W_RESP) && w_b_rdy_sel;
        mst_req_o.ar       = w_ar_sel;
        mst_req_o.ar_valid = (r_rd_state == R_ADDR) && w_ar_vld_sel;
        mst_req_o.r_ready  = (r_rd_state == R_DATA) && w_r_rdy_sel;
    end

    // Only the granted requester sees anything; responses pass through unmodified.
    always_comb begin
        slv0_resp_o = '0;
        slv1_resp_o = '0;
        if (w_wr_gnt == IDX_W'(1)) begin
            slv1_resp_o.aw_ready = w_wr_aw_rdy;
            slv1_resp_o.w_ready  = w_wr_w_rdy;
            slv1_resp_o.b_valid  = w_wr_b_vld;
            slv1_resp_o.b        = (r_wr_state == W_RESP) ? mst_resp_i.b : '0;
        end else begin
            slv0_resp_o.aw_ready = w_wr_aw_rdy;
            slv0_resp_o.w_ready  = w_wr_w_rdy;
            slv0_resp_o.b_valid  = w_wr_b_vld;
            slv0_resp_o.b        = (r_wr_state == W_RESP) ? mst_resp_i.b : '0;
        end
        if (w_rd_gnt == IDX_W'(1)) begin
            slv1_resp_o.ar_ready = w_rd_ar_rdy;
            slv1_resp_o.r_valid  = w_rd_r_vld;
            slv1_resp_o.r        = (r_rd_state == R_DATA) ? mst_resp_i.r : '0;
        end else begin
            slv0_resp_o.ar_ready = w_rd_ar_rdy;
            slv0_resp_o.r_valid  = w_rd_r_vld;
            slv0_resp_o.r        = (r_rd_state == R_DATA) ? mst_resp_i.r : '0;
        end
    end

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Scoreboard bench: requester tasks drive transactions, a master-side responder checks routing.
module tb_axi_master_arbiter;
    import axi_conf::*;
    import axi_io_pmp_arb_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_i = 1'b1;
    req_t  sreq [2];
    resp_t sresp [2];
    req_t  mreq;
    resp_t mresp;
    req_t  f_sreq0, f_sreq1, f_mreq;
    resp_t f_sresp0, f_sresp1, f_mresp;

    int    cyc = 0;
    int    n_chk = 0;
    int    n_pass = 0;
    exp_t  exp_aw_q[$];
    exp_t  exp_ar_q[$];
    int    aw_cycles[$];
    int    b_cycles[$];
    logic [1:0] bresp_val = 2'b00;
    bit    manual_r = 1'b0;
    bit    wr_done;
    int    rd_end, wr_end;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_master_arbiter #(.RR_EN(1)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .slv0_req_i(sreq[0]), .slv0_resp_o(sresp[0]),
        .slv1_req_i(sreq[1]), .slv1_resp_o(sresp[1]),
        .mst_req_o(mreq), .mst_resp_i(mresp)
    );

    axi_master_arbiter #(.RR_EN(0)) dut_fp (
        .clk_i(clk), .rst_i(rst_i),
        .slv0_req_i(f_sreq0), .slv0_resp_o(f_sresp0),
        .slv1_req_i(f_sreq1), .slv1_resp_o(f_sresp1),
        .mst_req_o(f_mreq), .mst_resp_i(f_mresp)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_rdy(input int i, input int which, input string tag);
        bit hs;
        hs = 1'b0;
        for (int g = 0; g < 100 && !hs; g++) begin
            @(negedge clk);
            case (which)
                0:       hs = sresp[i].aw_ready;
                1:       hs = sresp[i].w_ready;
                default: hs = sresp[i].ar_ready;
            endcase
            @(posedge clk); #1;
        end
        chk(tag, 64'(hs), 64'd1);
    endtask

    task automatic slv_write(input int i, input logic [7:0] id, input logic [31:0] addr,
                             input int len, input int wearly, input logic [1:0] eresp);
        bit hs;
        sreq[i].w.strb = '1;
        if (wearly > 0) begin
            sreq[i].w.data  = addr;
            sreq[i].w.last  = (len == 0);
            sreq[i].w_valid = 1'b1;
            repeat (wearly) begin
                @(negedge clk);
                chk("w_early_ready", 64'(sresp[i].w_ready), 64'd0);
                @(posedge clk); #1;
            end
        end
        sreq[i].aw.id    = id;
        sreq[i].aw.addr  = addr;
        sreq[i].aw.len   = 8'(len);
        sreq[i].aw_valid = 1'b1;
        wait_rdy(i, 0, "aw_handshake");
        sreq[i].aw_valid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            sreq[i].w.data  = addr + 32'(b);
            sreq[i].w.last  = (b == len);
            sreq[i].w_valid = 1'b1;
            wait_rdy(i, 1, "w_handshake");
        end
        sreq[i].w_valid = 1'b0;
        sreq[i].b_ready = 1'b1;
        hs = 1'b0;
        for (int g = 0; g < 100 && !hs; g++) begin
            @(negedge clk);
            if (sresp[i].b_valid) begin
                hs = 1'b1;
                chk("b_id", 64'(sresp[i].b.id), 64'(id));
                chk("b_resp", 64'(sresp[i].b.resp), 64'(eresp));
                chk("b_other_valid", 64'(sresp[1-i].b_valid), 64'd0);
            end
            @(posedge clk); #1;
        end
        chk("b_seen", 64'(hs), 64'd1);
        sreq[i].b_ready = 1'b0;
    endtask

    task automatic slv_read(input int i, input logic [7:0] id, input logic [31:0] addr, input int len);
        bit hs;
        sreq[i].ar.id    = id;
        sreq[i].ar.addr  = addr;
        sreq[i].ar.len   = 8'(len);
        sreq[i].ar_valid = 1'b1;
        wait_rdy(i, 2, "ar_handshake");
        sreq[i].ar_valid = 1'b0;
        sreq[i].r_ready  = 1'b1;
        for (int b = 0; b <= len; b++) begin
            hs = 1'b0;
            for (int g = 0; g < 100 && !hs; g++) begin
                @(negedge clk);
                if (sresp[i].r_valid) begin
                    hs = 1'b1;
                    chk("r_data", 64'(sresp[i].r.data), 64'(addr + 32'(b)));
                    chk("r_last", 64'(sresp[i].r.last), 64'(b == len));
                    chk("r_id", 64'(sresp[i].r.id), 64'(id));
                end
                @(posedge clk); #1;
            end
            chk("r_seen", 64'(hs), 64'd1);
        end
        sreq[i].r_ready = 1'b0;
    endtask

    task automatic mst_wr_loop();
        logic [7:0] cid, clen;
        logic [31:0] caddr;
        int beat;
        bit b_pend, b_done;
        exp_t e;
        cid = '0; clen = '0; caddr = '0; beat = 0; b_pend = 1'b0; b_done = 1'b0;
        forever begin
            @(negedge clk);
            if (mreq.aw_valid && mresp.aw_ready) begin
                cid = mreq.aw.id; caddr = mreq.aw.addr; clen = mreq.aw.len; beat = 0;
                aw_cycles.push_back(cyc);
                chk("aw_expected", 64'(exp_aw_q.size() > 0), 64'd1);
                if (exp_aw_q.size() > 0) begin
                    e = exp_aw_q.pop_front();
                    chk("aw_addr", 64'(caddr), 64'(e.addr));
                    chk("aw_len", 64'(clen), 64'(e.len));
                end
            end
            if (mreq.w_valid && mresp.w_ready) begin
                chk("w_data", 64'(mreq.w.data), 64'(caddr + 32'(beat)));
                chk("w_last", 64'(mreq.w.last), 64'(beat == int'(clen)));
                if (mreq.w.last) b_pend = 1'b1;
                beat++;
            end
            if (mresp.b_valid && mreq.b_ready) begin
                b_done = 1'b1;
                b_cycles.push_back(cyc);
            end
            @(posedge clk); #1;
            if (b_done) begin mresp.b_valid = 1'b0; b_done = 1'b0; end
            if (b_pend) begin
                mresp.b_valid = 1'b1; mresp.b.id = cid; mresp.b.resp = bresp_val; b_pend = 1'b0;
            end
        end
    endtask

    task automatic mst_rd_loop();
        logic [7:0] rid, rlen;
        logic [31:0] raddr;
        int rbeat;
        bit r_start, active;
        exp_t e;
        rid = '0; rlen = '0; raddr = '0; rbeat = 0; r_start = 1'b0; active = 1'b0;
        forever begin
            @(negedge clk);
            if (!manual_r) begin
                if (mreq.ar_valid && mresp.ar_ready) begin
                    rid = mreq.ar.id; raddr = mreq.ar.addr; rlen = mreq.ar.len; r_start = 1'b1;
                    chk("ar_expected", 64'(exp_ar_q.size() > 0), 64'd1);
                    if (exp_ar_q.size() > 0) begin
                        e = exp_ar_q.pop_front();
                        chk("ar_addr", 64'(raddr), 64'(e.addr));
                    end
                end
                if (mresp.r_valid && mreq.r_ready) rbeat++;
            end
            @(posedge clk); #1;
            if (!manual_r) begin
                if (r_start) begin rbeat = 0; r_start = 1'b0; active = 1'b1; end
                if (active) begin
                    if (rbeat > int'(rlen)) begin
                        mresp.r_valid = 1'b0; active = 1'b0;
                    end else begin
                        mresp.r_valid = 1'b1; mresp.r.id = rid; mresp.r.resp = 2'b00;
                        mresp.r.data = raddr + 32'(rbeat); mresp.r.last = (rbeat == int'(rlen));
                    end
                end
            end
        end
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : main
        int t0, nb, nf;
        bit hs;
        sreq[0] = '0; sreq[1] = '0; mresp = '0;
        f_sreq0 = '0; f_sreq1 = '0; f_mresp = '0;
        mresp.aw_ready = 1'b1; mresp.w_ready = 1'b1; mresp.ar_ready = 1'b1;
        sreq[0].aw_valid = 1'b1; sreq[0].ar_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mst_aw_valid", 64'(mreq.aw_valid), 64'd0);
        chk("rst_mst_ar_valid", 64'(mreq.ar_valid), 64'd0);
        chk("rst_s0_aw_ready", 64'(sresp[0].aw_ready), 64'd0);
        chk("rst_s0_ar_ready", 64'(sresp[0].ar_ready), 64'd0);
        chk("rst_mst_w_valid", 64'(mreq.w_valid), 64'd0);
        @(posedge clk); #1;
        rst_i = 1'b0; sreq[0].aw_valid = 1'b0; sreq[0].ar_valid = 1'b0;
        fork mst_wr_loop(); mst_rd_loop(); join_none
        @(posedge clk); #1;

        // Round-robin tie on writes: slave0 first, slave1 after the bubble.
        t0 = cyc;
        exp_aw_q.push_back('{addr: 32'h0000_1000, len: 8'd1});
        exp_aw_q.push_back('{addr: 32'h0000_2000, len: 8'd0});
        fork
            slv_write(0, 8'h01, 32'h0000_1000, 1, 0, 2'b00);
            slv_write(1, 8'h02, 32'h0000_2000, 0, 0, 2'b00);
        join
        chk("rr_aw_count", 64'(aw_cycles.size()), 64'd2);
        chk("rr_first_latency", 64'(aw_cycles[0]), 64'(t0 + 1));
        chk("rr_second_after_idle", 64'(aw_cycles[1]), 64'(b_cycles[0] + 2));

        // Concurrent write from slave1 and read from slave0.
        repeat (2) @(posedge clk); #1;
        wr_done = 1'b0;
        exp_aw_q.push_back('{addr: 32'h0000_4000, len: 8'd3});
        exp_ar_q.push_back('{addr: 32'h0000_5000, len: 8'd0});
        fork
            begin slv_write(1, 8'h11, 32'h0000_4000, 3, 0, 2'b00); wr_end = cyc; wr_done = 1'b1; end
            begin slv_read(0, 8'h22, 32'h0000_5000, 0); rd_end = cyc; end
            for (int k = 0; k < 100 && !wr_done; k++) begin
                @(negedge clk);
                chk("s0_w_ready_blocked", 64'(sresp[0].w_ready), 64'd0);
            end
        join
        chk("read_overlaps_write", 64'(rd_end < wr_end), 64'd1);

        // Early W data from slave0 is held off until its AW is granted.
        repeat (2) @(posedge clk); #1;
        exp_aw_q.push_back('{addr: 32'h0000_6000, len: 8'd2});
        slv_write(0, 8'h33, 32'h0000_6000, 2, 3, 2'b00);

        // Error response with a distinct id is passed through to slave1 only.
        repeat (2) @(posedge clk); #1;
        bresp_val = 2'b10;
        exp_aw_q.push_back('{addr: 32'h0000_7000, len: 8'd0});
        slv_write(1, 8'h5A, 32'h0000_7000, 0, 0, 2'b10);
        bresp_val = 2'b00;

        // Reset in the middle of a 4-beat read.
        repeat (2) @(posedge clk); #1;
        manual_r = 1'b1;
        sreq[0].ar.id = 8'h44; sreq[0].ar.addr = 32'h0000_8000; sreq[0].ar.len = 8'd3;
        sreq[0].ar_valid = 1'b1; sreq[0].r_ready = 1'b1;
        hs = 1'b0;
        for (int g = 0; g < 20 && !hs; g++) begin
            @(negedge clk); hs = mreq.ar_valid; @(posedge clk); #1;
        end
        chk("rst_ar_seen", 64'(hs), 64'd1);
        sreq[0].ar_valid = 1'b0;
        mresp.r_valid = 1'b1; mresp.r.last = 1'b0; mresp.r.id = 8'h44;
        nb = 0;
        for (int g = 0; g < 20 && nb < 2; g++) begin
            @(negedge clk);
            if (sresp[0].r_valid && mreq.r_ready) nb++;
            @(posedge clk); #1;
        end
        chk("rst_two_beats", 64'(nb), 64'd2);
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("post_rst_mst_r_ready", 64'(mreq.r_ready), 64'd0);
        chk("post_rst_s0_r_valid", 64'(sresp[0].r_valid), 64'd0);
        chk("post_rst_s0_ar_ready", 64'(sresp[0].ar_ready), 64'd0);
        chk("post_rst_mst_ar_valid", 64'(mreq.ar_valid), 64'd0);
        chk("post_rst_rd_state", 64'(dut.r_rd_state), 64'(R_IDLE));
        chk("post_rst_rd_prio", 64'(dut.u_rd_arb.r_prio), 64'd0);
        chk("post_rst_rd_grant", 64'(dut.u_rd_arb.r_grant), 64'd0);
        @(posedge clk); #1;
        mresp.r_valid = 1'b0; sreq[0].r_ready = 1'b0; manual_r = 1'b0;

        // Fixed priority: continuous reads from both, slave0 wins every time.
        f_mresp.ar_ready = 1'b1; f_mresp.r_valid = 1'b1; f_mresp.r.last = 1'b1;
        f_sreq0.ar.addr = 32'h0000_A000; f_sreq0.ar_valid = 1'b1; f_sreq0.r_ready = 1'b1;
        f_sreq1.ar.addr = 32'h0000_B000; f_sreq1.ar_valid = 1'b1; f_sreq1.r_ready = 1'b1;
        nf = 0;
        for (int g = 0; g < 40 && nf < 4; g++) begin
            @(negedge clk);
            chk("fp_s1_ar_ready", 64'(f_sresp1.ar_ready), 64'd0);
            if (f_mreq.ar_valid && f_mresp.ar_ready) begin
                chk("fp_ar_addr", 64'(f_mreq.ar.addr), 64'h0000_A000);
                nf++;
            end
            @(posedge clk); #1;
        end
        chk("fp_ar_count", 64'(nf), 64'd4);
        f_sreq0 = '0; f_sreq1 = '0;

        repeat (3) @(posedge clk);
        chk("aw_queue_drained", 64'(exp_aw_q.size()), 64'd0);
        chk("ar_queue_drained", 64'(exp_ar_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
